atc_stage_reg: RTL

- Parametrised pipeline inter-stage register for the 5-stage MIPS core.
- Carries hazard-tracking tags (read-address fields, write address, result-source code) plus a data payload and a valid bit from stage N to stage N+1.
- Adds stall (hold), flush (bubble insert) and write-enable qualification so a single module instances every D/E/M/W boundary.
- Feeds the hazard/forwarding unit, which compares ra/wa tags across stages.

---
 rtl/atc_stage_reg.sv | 112 +++++++++++
 1 files changed

// File: rtl/atc_stage_reg.sv
// Purpose : pipeline inter-stage register carrying hazard tags, payload and valid bit.
// Latency : 1 cycle, input to output; wr_en_o is combinational from the registers.
// Backpress: stall_i holds all contents; flush_i (or valid_i=0) loads the all-zero bubble.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stall_i         hold current contents (lower priority than flush_i)
//   flush_i         replace contents with a bubble
//   valid_i         upstream stage holds a real instruction
//   ra_i / ra_o     NREAD source-register addresses, field k at [k*REG_AW +: REG_AW]
//   wa_i / wa_o     destination register address
//   res_i / res_o   result-source code, 0 means no register write
//   data_i / data_o payload (PC, ALU result, ...)
//   valid_o         registered valid
//   wr_en_o         valid_o & (res_o != 0) & (wa_o != 0)
//   stall_cnt_o     saturating count of stalled edges
//   bubble_cnt_o    saturating count of bubble-loading edges
//
// Optional feature macro: ATC_STAT_EN builds the two statistics counters.
// Without it both counter ports are tied to 0 and no counter flops exist.
// Parameter limits: NREAD in 1..4, DATA_W >= 1.

module atc_stage_reg #(
    parameter int REG_AW = 5,
    parameter int NREAD  = 2,
    parameter int RES_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    input  logic [NREAD*REG_AW-1:0] ra_i,
    input  logic [REG_AW-1:0]       wa_i,
    input  logic [RES_W-1:0]        res_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic                    valid_o,
    output logic [NREAD*REG_AW-1:0] ra_o,
    output logic [REG_AW-1:0]       wa_o,
    output logic [RES_W-1:0]        res_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    wr_en_o,
    output logic [15:0]             stall_cnt_o,
    output logic [15:0]             bubble_cnt_o
);

    // A bubble is loaded on flush (which overrides stall) or when an
    // unstalled edge sees no real instruction upstream, so stale tags
    // never reach the hazard unit.
    logic load_bubble;
    logic load_capture;

    assign load_bubble  = flush_i | (~stall_i & ~valid_i);
    assign load_capture = ~flush_i & ~stall_i & valid_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            ra_o    <= '0;
            wa_o    <= '0;
            res_o   <= '0;
            data_o  <= '0;
        end else if (load_bubble) begin
            valid_o <= 1'b0;
            ra_o    <= '0;
            wa_o    <= '0;
            res_o   <= '0;
            data_o  <= '0;
        end else if (load_capture) begin
            valid_o <= 1'b1;
            ra_o    <= ra_i;
            wa_o    <= wa_i;
            res_o   <= res_i;
            data_o  <= data_i;
        end
        // remaining case is a stall: every register holds
    end

    // $zero is hardwired, so wa=0 never produces a write.
    assign wr_en_o = valid_o & (res_o != '0) & (wa_o != '0);

`ifdef ATC_STAT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] bubble_cnt_q;
    logic        stall_edge;

    assign stall_edge = stall_i & ~flush_i;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= 16'd0;
            bubble_cnt_q <= 16'd0;
        end else begin
            if (stall_edge && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (load_bubble && (bubble_cnt_q != 16'hFFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign stall_cnt_o  = 16'd0;
    assign bubble_cnt_o = 16'd0;
`endif

endmodule
